// File: rtl/seg_display_scheduler.sv
// ============================================================================
// Module   : seg_display_scheduler
// Purpose  : Double-dabble conversion of an 8-bit result plus a multiplexed
//            scan of three BCD digits onto a shared seven-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_scheduler #(
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1,
  localparam int N      = 8,
  localparam int DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [N-1:0]      value,
  output logic              busy,
  output logic [3:0]        bcd_out,
  output logic [DIGITS-1:0] dig_en
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_CONVERT = 2'd1;
  localparam logic [1:0] c_UPDATE  = 2'd2;

  localparam int             c_PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(SCAN_DIV - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [N-1:0]    r_shift;
  logic [9:0]      r_bcd;
  logic [2:0]      r_cnt;
  logic [1:0]      r_hund;
  logic [3:0]      r_tens;
  logic [3:0]      r_ones;
  logic [3:0]      w_tens_adj;
  logic [3:0]      w_ones_adj;
  logic [c_PW-1:0] r_pre;
  logic [1:0]      r_idx;
  logic            w_pre_wrap;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:    if (load) w_state_nxt = c_CONVERT;
      c_CONVERT: if (r_cnt == 3'd7) w_state_nxt = c_UPDATE;
      c_UPDATE:  w_state_nxt = c_IDLE;
      default:   w_state_nxt = c_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    case (r_state)
      c_CONVERT, c_UPDATE: busy = 1'b1;
      default:             busy = 1'b0;
    endcase
  end

  // The hundreds field is at most 2 while shifting an 8-bit value, so it never needs +3.
  assign w_tens_adj = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
  assign w_ones_adj = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_hund  <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (load) begin
            r_shift <= value;
            r_bcd   <= '0;
            r_cnt   <= '0;
          end
        end
        c_CONVERT: begin
          r_bcd   <= {r_bcd[8], w_tens_adj, w_ones_adj, r_shift[N-1]};
          r_shift <= {r_shift[N-2:0], 1'b0};
          r_cnt   <= r_cnt + 3'd1;
        end
        c_UPDATE: begin
          r_hund <= r_bcd[9:8];
          r_tens <= r_bcd[7:4];
          r_ones <= r_bcd[3:0];
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------- Digit scan, free-running ----------------
  assign w_pre_wrap = (r_pre == c_PRE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (w_pre_wrap) begin
      r_pre <= '0;
      r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Blanked slots keep driving their digit so the decoder input stays in 0..9.
  always_comb begin
    bcd_out = r_ones;
    dig_en  = 3'b110;
    case (r_idx)
      2'd1: begin
        bcd_out = r_tens;
        dig_en  = (BLANK_LZ && (r_hund == 2'd0) && (r_tens == 4'd0)) ? 3'b111 : 3'b101;
      end
      2'd2: begin
        bcd_out = {2'b00, r_hund};
        dig_en  = (BLANK_LZ && (r_hund == 2'd0)) ? 3'b111 : 3'b011;
      end
      default: begin
        bcd_out = r_ones;
        dig_en  = 3'b110;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_display_scheduler.sv
// ============================================================================
// Module   : tb_seg_display_scheduler
// Purpose  : Scoreboard bench for seg_display_scheduler (blanking and non-blanking instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_display_scheduler;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] value;
  logic       busy_a, busy_b;
  logic [3:0] bcd_a, bcd_b;
  logic [2:0] en_a, en_b;

  int errors = 0;
  int checks = 0;

  // Scoreboard entries: {hundreds, tens, ones}
  logic [11:0] sb_q[$];
  logic [3:0]  exp_h, exp_t, exp_o;

  logic [3:0] obs_bcd_a[3];
  logic [2:0] obs_en_a[3];
  logic [3:0] obs_bcd_b[3];
  logic [2:0] obs_en_b[3];
  logic [3:0] obs_max;

  int m_pre_a, m_idx_a, m_idx_b;

  seg_display_scheduler #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy_a), .bcd_out(bcd_a), .dig_en(en_a)
  );

  seg_display_scheduler #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy_b), .bcd_out(bcd_b), .dig_en(en_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference slot index for each instance (SCAN_DIV 4 and 1)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pre_a <= 0;
      m_idx_a <= 0;
      m_idx_b <= 0;
    end else begin
      if (m_pre_a == 3) begin
        m_pre_a <= 0;
        m_idx_a <= (m_idx_a == 2) ? 0 : m_idx_a + 1;
      end else begin
        m_pre_a <= m_pre_a + 1;
      end
      m_idx_b <= (m_idx_b == 2) ? 0 : m_idx_b + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] digits_of(input int v);
    digits_of = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Collects what each slot shows over a full scan rotation of both instances.
  task automatic observe();
    for (int s = 0; s < 3; s++) begin
      obs_bcd_a[s] = 4'hx; obs_en_a[s] = 3'bxxx;
      obs_bcd_b[s] = 4'hx; obs_en_b[s] = 3'bxxx;
    end
    obs_max = 4'd0;
    repeat (12) begin
      @(negedge clk);
      obs_bcd_a[m_idx_a] = bcd_a;
      obs_en_a[m_idx_a]  = en_a;
      obs_bcd_b[m_idx_b] = bcd_b;
      obs_en_b[m_idx_b]  = en_b;
      if (bcd_a > obs_max) obs_max = bcd_a;
      if (bcd_b > obs_max) obs_max = bcd_b;
    end
  endtask

  // One full conversion: busy high after E0..E8, low after E9, then pop the expectation.
  task automatic run_conv(input int v);
    @(negedge clk);
    load  = 1'b1;
    value = 8'(v);
    sb_q.push_back(digits_of(v));
    for (int e = 0; e <= 8; e++) begin
      @(posedge clk);
      #1;
      load = 1'b0;
      checks++;
      if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
        errors++;
        $display("FAIL busy_E%0d v=%0d: got %b/%b expected 1/1", e, v, busy_a, busy_b);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL busy_E9 v=%0d: got %b/%b expected 0/0", v, busy_a, busy_b);
    end
    {exp_h, exp_t, exp_o} = sb_q.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; value = 8'd0;
    #1;
    checks++;
    if (busy_a !== 1'b0 || en_a !== 3'b110 || bcd_a !== 4'd0) begin
      errors++;
      $display("FAIL reset_init: got busy=%b en=%b bcd=%0d expected 0 110 0", busy_a, en_a, bcd_a);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_convert();
    @(negedge clk);
    load = 1'b1; value = 8'd200;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy_a !== 1'b0 || en_a !== 3'b110 || bcd_a !== 4'd0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b en=%b bcd=%0d expected 0 110 0", busy_a, en_a, bcd_a);
    end
    @(negedge clk);
    rst = 1'b0;
    observe();
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (obs_bcd_a[s] !== 4'd0 || obs_bcd_b[s] !== 4'd0) begin
        errors++;
        $display("FAIL reset_zero slot%0d: got %0d/%0d expected 0", s, obs_bcd_a[s], obs_bcd_b[s]);
      end
    end
    checks++;
    if (obs_en_a[0] !== 3'b110 || obs_en_a[1] !== 3'b111 || obs_en_a[2] !== 3'b111) begin
      errors++;
      $display("FAIL reset_blank: got %b %b %b expected 110 111 111", obs_en_a[0], obs_en_a[1], obs_en_a[2]);
    end
  endtask

  task automatic test_255();
    run_conv(255);
    observe();
    checks++;
    if (obs_bcd_a[0] !== 4'd5 || obs_bcd_a[1] !== 4'd5 || obs_bcd_a[2] !== 4'd2) begin
      errors++;
      $display("FAIL v255_digits: got %0d %0d %0d expected 5 5 2", obs_bcd_a[0], obs_bcd_a[1], obs_bcd_a[2]);
    end
    checks++;
    if (obs_en_a[0] !== 3'b110 || obs_en_a[1] !== 3'b101 || obs_en_a[2] !== 3'b011) begin
      errors++;
      $display("FAIL v255_en: got %b %b %b expected 110 101 011", obs_en_a[0], obs_en_a[1], obs_en_a[2]);
    end
  endtask

  task automatic test_blank_7();
    run_conv(7);
    observe();
    checks++;
    if (obs_bcd_a[0] !== exp_o || obs_en_a[0] !== 3'b110) begin
      errors++;
      $display("FAIL v7_ones: got %0d/%b expected %0d/110", obs_bcd_a[0], obs_en_a[0], exp_o);
    end
    checks++;
    if (obs_en_a[1] !== 3'b111 || obs_en_a[2] !== 3'b111) begin
      errors++;
      $display("FAIL v7_blank: got %b %b expected 111 111", obs_en_a[1], obs_en_a[2]);
    end
    checks++;
    if (obs_bcd_b[0] !== 4'd7 || obs_bcd_b[1] !== 4'd0 || obs_bcd_b[2] !== 4'd0 ||
        obs_en_b[0] !== 3'b110 || obs_en_b[1] !== 3'b101 || obs_en_b[2] !== 3'b011) begin
      errors++;
      $display("FAIL v7_noblank: got %0d %0d %0d en %b %b %b expected 7 0 0 en 110 101 011",
               obs_bcd_b[0], obs_bcd_b[1], obs_bcd_b[2], obs_en_b[0], obs_en_b[1], obs_en_b[2]);
    end
  endtask

  task automatic test_100();
    run_conv(100);
    observe();
    checks++;
    if (obs_bcd_a[0] !== 4'd0 || obs_bcd_a[1] !== 4'd0 || obs_bcd_a[2] !== 4'd1) begin
      errors++;
      $display("FAIL v100_digits: got %0d %0d %0d expected 0 0 1", obs_bcd_a[0], obs_bcd_a[1], obs_bcd_a[2]);
    end
    checks++;
    if (obs_en_a[1] !== 3'b101 || obs_en_a[2] !== 3'b011) begin
      errors++;
      $display("FAIL v100_en: got %b %b expected 101 011", obs_en_a[1], obs_en_a[2]);
    end
  endtask

  task automatic test_drop_while_busy();
    @(negedge clk);
    load = 1'b1; value = 8'd42;
    sb_q.push_back(digits_of(42));
    @(posedge clk);
    #1 load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    load = 1'b1; value = 8'd99;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    load = 1'b1; value = 8'd99;
    @(posedge clk);
    #1 load = 1'b0;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL drop_E9_busy: got %b expected 0", busy_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL drop_E10_busy: got %b expected 0", busy_a);
    end
    {exp_h, exp_t, exp_o} = sb_q.pop_front();
    observe();
    checks++;
    if (obs_bcd_b[0] !== exp_o || obs_bcd_b[1] !== exp_t || obs_bcd_b[2] !== exp_h) begin
      errors++;
      $display("FAIL drop_digits: got %0d%0d%0d expected %0d%0d%0d",
               obs_bcd_b[2], obs_bcd_b[1], obs_bcd_b[0], exp_h, exp_t, exp_o);
    end
  endtask

  task automatic test_back_to_back();
    run_conv(63);
    run_conv(180);
    observe();
    checks++;
    if (obs_bcd_b[0] !== 4'd0 || obs_bcd_b[1] !== 4'd8 || obs_bcd_b[2] !== 4'd1) begin
      errors++;
      $display("FAIL b2b_digits: got %0d%0d%0d expected 180", obs_bcd_b[2], obs_bcd_b[1], obs_bcd_b[0]);
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 256; v++) begin
      run_conv(v);
      observe();
      checks++;
      if (obs_bcd_b[0] !== exp_o || obs_bcd_b[1] !== exp_t || obs_bcd_b[2] !== exp_h) begin
        errors++;
        $display("FAIL sweep v=%0d: got %0d%0d%0d expected %0d%0d%0d",
                 v, obs_bcd_b[2], obs_bcd_b[1], obs_bcd_b[0], exp_h, exp_t, exp_o);
      end
      checks++;
      if (obs_bcd_a[0] !== exp_o || obs_bcd_a[1] !== exp_t || obs_bcd_a[2] !== exp_h) begin
        errors++;
        $display("FAIL sweep_blank v=%0d: got %0d%0d%0d expected %0d%0d%0d",
                 v, obs_bcd_a[2], obs_bcd_a[1], obs_bcd_a[0], exp_h, exp_t, exp_o);
      end
      checks++;
      if (obs_en_a[1] !== ((exp_h == 0 && exp_t == 0) ? 3'b111 : 3'b101) ||
          obs_en_a[2] !== ((exp_h == 0) ? 3'b111 : 3'b011)) begin
        errors++;
        $display("FAIL sweep_en v=%0d: got %b %b", v, obs_en_a[1], obs_en_a[2]);
      end
      checks++;
      if (obs_max > 4'd9) begin
        errors++;
        $display("FAIL sweep_range v=%0d: got %0d expected <=9", v, obs_max);
      end
    end
  endtask

  initial begin
    test_reset();
    test_255();
    test_reset_mid_convert();
    test_blank_7();
    test_100();
    test_drop_while_busy();
    test_back_to_back();
    test_sweep();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
